// File: rtl/uart_dbg_pkg.sv
// Shared types and helpers for the hex-dump debug streamer.
package uart_dbg_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HEX  = 3'd1,
    SEP  = 3'd2,
    CR   = 3'd3,
    LF   = 3'd4
  } dbg_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // 4-bit value to uppercase ASCII hex digit.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/dbg_tick_gen.sv
// Periodic single-cycle tick; counter held at zero while disabled.
module dbg_tick_gen #(
  parameter int PERIOD_CYCLES = 20000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_enable,
  output logic o_tick
);

  generate
    if (PERIOD_CYCLES == 0) begin : g_off
      logic w_unused;
      assign w_unused = ^{i_clk, i_rst, i_enable};
      assign o_tick   = 1'b0;
    end else begin : g_on
      localparam int CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
      localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);
      logic [CW-1:0] r_cnt;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                r_cnt <= '0;
        else if (!i_enable)       r_cnt <= '0;
        else if (r_cnt == LAST)   r_cnt <= '0;
        else                      r_cnt <= r_cnt + 1'b1;
      end

      assign o_tick = i_enable && (r_cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/uart_hex_dump.sv
// Snapshots NUM_CH words and streams them as one ASCII hex line (SEP-separated, CR LF).
// tx_valid/tx_data are registered; a byte moves on a posedge with tx_valid & tx_ready,
// and both hold steady until that transfer happens.
module uart_hex_dump
  import uart_dbg_pkg::*;
#(
  parameter int         WORD_BITS     = 16,
  parameter int         NUM_CH        = 4,
  parameter int         PERIOD_CYCLES = 20000000,
  parameter logic [7:0] SEP_CHAR      = 8'h20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        trigger,
  input  logic [NUM_CH*WORD_BITS-1:0] data_in,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        busy,
  output logic                        frame_done,
  output logic [7:0]                  overrun_cnt,
  output dbg_state_e                  o_dbg_state
);

  localparam int NIB = WORD_BITS / 4;
  localparam int DW  = NUM_CH * WORD_BITS;
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int NW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CHW-1:0] LAST_CH = CHW'(NUM_CH - 1);
  localparam logic [NW-1:0]  NIB_TOP = NW'(NIB - 1);

  generate
    if ((WORD_BITS % 4) != 0 || WORD_BITS < 4) begin : g_bad_word
      $error("uart_hex_dump: WORD_BITS must be a positive multiple of 4");
    end
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_ch
      $error("uart_hex_dump: NUM_CH must be 1..16");
    end
  endgenerate

  function automatic logic [3:0] nib_at(input logic [DW-1:0] v, input logic [CHW-1:0] c,
                                        input logic [NW-1:0] n);
    logic [DW-1:0] s;
    s = v >> (int'(c) * WORD_BITS + int'(n) * 4);
    return s[3:0];
  endfunction

  dbg_state_e     r_state, n_state;
  logic [DW-1:0]  r_snap, n_snap;
  logic [CHW-1:0] r_ch, n_ch;
  logic [NW-1:0]  r_nib, n_nib;
  logic [7:0]     r_tx_data, n_data;
  logic           r_tx_valid, n_valid;
  logic           r_busy, n_busy;
  logic           r_done, n_done;
  logic           r_pending, n_pend;
  logic [7:0]     r_ovr, n_ovr;

  logic w_tick, w_event, w_req, w_xfer;

  dbg_tick_gen #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_tick (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_enable (enable),
    .o_tick   (w_tick)
  );

  assign w_event = w_tick | trigger;
  assign w_req   = enable & (w_event | r_pending);
  assign w_xfer  = r_tx_valid & tx_ready;

  always_comb begin
    n_state = r_state;
    n_snap  = r_snap;
    n_ch    = r_ch;
    n_nib   = r_nib;
    n_data  = r_tx_data;
    n_valid = r_tx_valid;
    n_busy  = r_busy;
    n_done  = 1'b0;
    n_pend  = r_pending;
    n_ovr   = r_ovr;

    // Requests during a frame: remember one, count the rest as overruns.
    if (!enable) begin
      n_pend = 1'b0;
    end else if (r_state != IDLE && w_event) begin
      if (!r_pending)          n_pend = 1'b1;
      else if (r_ovr != 8'hFF) n_ovr  = r_ovr + 8'd1;
    end

    case (r_state)
      IDLE: begin
        if (w_req) begin
          n_snap  = data_in;
          n_ch    = '0;
          n_nib   = NIB_TOP;
          n_data  = hex_ascii(data_in[WORD_BITS-1 -: 4]);
          n_valid = 1'b1;
          n_busy  = 1'b1;
          n_pend  = 1'b0;
          n_state = HEX;
        end
      end
      HEX: begin
        if (w_xfer) begin
          if (r_nib != '0) begin
            n_nib  = r_nib - 1'b1;
            n_data = hex_ascii(nib_at(r_snap, r_ch, r_nib - 1'b1));
          end else if (r_ch != LAST_CH) begin
            n_data  = SEP_CHAR;
            n_state = SEP;
          end else begin
            n_data  = ASCII_CR;
            n_state = CR;
          end
        end
      end
      SEP: begin
        if (w_xfer) begin
          n_ch    = r_ch + 1'b1;
          n_nib   = NIB_TOP;
          n_data  = hex_ascii(nib_at(r_snap, r_ch + 1'b1, NIB_TOP));
          n_state = HEX;
        end
      end
      CR: begin
        if (w_xfer) begin
          n_data  = ASCII_LF;
          n_state = LF;
        end
      end
      LF: begin
        if (w_xfer) begin
          n_valid = 1'b0;
          n_busy  = 1'b0;
          n_done  = 1'b1;
          n_state = IDLE;
        end
      end
      default: n_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_snap     <= '0;
      r_ch       <= '0;
      r_nib      <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pending  <= 1'b0;
      r_ovr      <= '0;
    end else begin
      r_state    <= n_state;
      r_snap     <= n_snap;
      r_ch       <= n_ch;
      r_nib      <= n_nib;
      r_tx_data  <= n_data;
      r_tx_valid <= n_valid;
      r_busy     <= n_busy;
      r_done     <= n_done;
      r_pending  <= n_pend;
      r_ovr      <= n_ovr;
    end
  end

  assign tx_data     = r_tx_data;
  assign tx_valid    = r_tx_valid;
  assign busy        = r_busy;
  assign frame_done  = r_done;
  assign overrun_cnt = r_ovr;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_hex_dump.sv
// Bench for uart_hex_dump: string-based line model, scoreboard queue, periodic-timer checks.
module tb_uart_hex_dump;
  import uart_dbg_pkg::*;

  localparam int WB        = 16;
  localparam int NCH       = 2;
  localparam int DW        = WB * NCH;
  localparam int FRAME_LEN = NCH * (WB / 4) + (NCH - 1) + 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main DUT (trigger only)
  logic          enable = 1'b1, trigger = 1'b0, tx_ready = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic [7:0]    tx_data, overrun_cnt;
  logic          tx_valid, busy, frame_done;
  dbg_state_e    dbg_state;

  // timer DUT
  logic          enable_t = 1'b0, trigger_t = 1'b0, tx_ready_t = 1'b1;
  logic [DW-1:0] data_in_t = 32'hCAFE_0123;
  logic [7:0]    tx_data_t, overrun_cnt_t;
  logic          tx_valid_t, busy_t, frame_done_t;
  dbg_state_e    dbg_state_t;

  uart_hex_dump #(.WORD_BITS(WB), .NUM_CH(NCH), .PERIOD_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .enable(enable), .trigger(trigger), .data_in(data_in),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .frame_done(frame_done), .overrun_cnt(overrun_cnt), .o_dbg_state(dbg_state)
  );

  uart_hex_dump #(.WORD_BITS(WB), .NUM_CH(NCH), .PERIOD_CYCLES(200)) dut_t (
    .clk(clk), .rst(rst), .enable(enable_t), .trigger(trigger_t), .data_in(data_in_t),
    .tx_data(tx_data_t), .tx_valid(tx_valid_t), .tx_ready(tx_ready_t), .busy(busy_t),
    .frame_done(frame_done_t), .overrun_cnt(overrun_cnt_t), .o_dbg_state(dbg_state_t)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  int         rise_q[$];
  int         rx_cnt = 0, busy_cyc = 0, done_cnt = 0;
  int         cyc = 0, rel = 0;
  logic       hold_prev = 1'b0, prev_valid_t = 1'b0, rnd_ready = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: one line = hex words joined by spaces, then CR LF
  task automatic push_frame(input logic [DW-1:0] d);
    string s;
    logic [WB-1:0] w;
    s = "";
    for (int k = 0; k < NCH; k++) begin
      w = d[k*WB +: WB];
      s = {s, $sformatf("%h", w)};
      if (k < NCH - 1) s = {s, " "};
    end
    s = {s.toupper(), "\r\n"};
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // driver tasks
  task automatic pulse_trigger();
    @(posedge clk); #1 trigger = 1'b1;
    @(posedge clk); #1 trigger = 1'b0;
  endtask

  task automatic clr_mon();
    rx_cnt = 0; busy_cyc = 0; done_cnt = 0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin @(posedge clk); k++; end
    check("frames_done", done_cnt, target);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_rx(input int n);
    int k;
    k = 0;
    while (rx_cnt < n && k < 400) begin @(posedge clk); k++; end
    check("wait_rx", rx_cnt >= n, 1);
  endtask

  task automatic wait_rel(input int n);
    while (cyc - rel < n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    rel = cyc;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk); #1;
    tx_ready = rnd_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  // monitor / scoreboard, sampled mid-cycle
  initial forever begin
    @(negedge clk);
    if (rst) begin
      hold_prev    = 1'b0;
      prev_valid_t = 1'b0;
    end else begin
      if (busy) busy_cyc++;
      if (frame_done) done_cnt++;
      if (hold_prev) begin
        check("hold_valid", tx_valid, 1);
        check("hold_data", tx_data, prev_data);
      end
      if (tx_valid && tx_ready) begin
        rx_cnt++;
        check("byte_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check($sformatf("byte%0d", rx_cnt), tx_data, exp_q.pop_front());
      end
      hold_prev = tx_valid && !tx_ready;
      prev_data = tx_data;
      if (tx_valid_t && !prev_valid_t) rise_q.push_back(cyc - rel);
      prev_valid_t = tx_valid_t;
    end
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  logic [7:0] lit [11] = '{8'h31, 8'h32, 8'h41, 8'h30, 8'h20, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
  logic [DW-1:0] d;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", overrun_cnt, 0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0;
    rel = cyc;
    repeat (2) @(posedge clk);

    // basic frame, ready always high
    clr_mon();
    data_in = {16'hBEEF, 16'h12A0};
    foreach (lit[i]) exp_q.push_back(lit[i]);
    @(posedge clk); #1 trigger = 1'b1;
    check("pre_valid", tx_valid, 0);
    @(posedge clk); #1 trigger = 1'b0;
    check("latency_valid", tx_valid, 1);
    check("first_byte", tx_data, 8'h31);
    wait_done(1, 200);
    check("busy_cycles", busy_cyc, FRAME_LEN);
    check("bytes_rx", rx_cnt, FRAME_LEN);
    check("exp_empty", exp_q.size(), 0);
    check("idle_after", busy, 0);

    // same line, 30% ready
    clr_mon();
    rnd_ready = 1'b1;
    push_frame(data_in);
    pulse_trigger();
    wait_done(1, 400);
    check("rnd_bytes", rx_cnt, FRAME_LEN);
    check("rnd_exp_empty", exp_q.size(), 0);

    // random data, random ready
    for (int it = 0; it < 4; it++) begin
      clr_mon();
      data_in = $urandom();
      push_frame(data_in);
      pulse_trigger();
      wait_done(1, 400);
      check("rand_exp_empty", exp_q.size(), 0);
    end
    rnd_ready = 1'b0;

    // snapshot isolation
    clr_mon();
    data_in = {16'hBEEF, 16'h12A0};
    push_frame(data_in);
    pulse_trigger();
    wait_rx(2);
    #1 data_in = '0;
    wait_done(1, 200);
    push_frame('0);
    pulse_trigger();
    wait_done(2, 200);
    check("snap_exp_empty", exp_q.size(), 0);

    // enable dropped with a request pending
    clr_mon();
    data_in = $urandom();
    push_frame(data_in);
    pulse_trigger();
    wait_rx(3);
    pulse_trigger();
    @(posedge clk); #1 enable = 1'b0;
    wait_done(1, 200);
    repeat (20) @(posedge clk);
    #1 enable = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("endrop_frames", done_cnt, 1);
    check("endrop_exp_empty", exp_q.size(), 0);
    check("endrop_idle", busy, 0);

    // overrun: three requests during a frame
    clr_mon();
    data_in = $urandom();
    push_frame(data_in);
    push_frame(data_in);
    pulse_trigger();
    repeat (2) @(posedge clk);
    repeat (3) pulse_trigger();
    wait_done(2, 400);
    repeat (20) @(posedge clk);
    #1;
    check("ovr_frames", done_cnt, 2);
    check("ovr_exp_empty", exp_q.size(), 0);
    check("ovr_count", overrun_cnt, 2);

    // reset mid-frame
    clr_mon();
    data_in = $urandom();
    push_frame(data_in);
    pulse_trigger();
    wait_rx(5);
    #1 rst = 1'b1;
    #1;
    check("midrst_valid", tx_valid, 0);
    check("midrst_overrun", overrun_cnt, 0);
    check("midrst_busy", busy, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    clr_mon();
    repeat (20) @(posedge clk);
    #1;
    check("midrst_silent", rx_cnt, 0);
    check("midrst_no_valid", tx_valid, 0);
    data_in = $urandom();
    push_frame(data_in);
    pulse_trigger();
    wait_done(1, 200);
    check("midrst_bytes", rx_cnt, FRAME_LEN);
    check("midrst_exp_empty", exp_q.size(), 0);

    // periodic timer, PERIOD_CYCLES=200
    enable_t = 1'b1;
    rise_q.delete();
    do_reset();
    wait_rel(450);
    check("tick_count", rise_q.size(), 2);
    if (rise_q.size() == 2) begin
      check("tick_first", rise_q[0], 200);
      check("tick_second", rise_q[1], 400);
    end

    rise_q.delete();
    do_reset();
    wait_rel(250);
    enable_t = 1'b0;
    wait_rel(450);
    check("tick_drop_count", rise_q.size(), 1);
    if (rise_q.size() == 1) check("tick_drop_first", rise_q[0], 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_hex_dump.md
Name: uart_hex_dump

Overview:
Parametrised debug streamer that snapshots NUM_CH data words and emits them as one ASCII hex line. Each line is channels separated by SEP_CHAR and terminated by CR LF. Lines are sent periodically, on an external trigger, or both. Output is a byte-wide valid/ready stream that feeds the existing UART transmitter, so one debug UART pin can carry several internal buses.

Parameters:
WORD_BITS, 16, bits per channel; must be a multiple of 4 (elaboration error otherwise); NIB = WORD_BITS/4
NUM_CH, 4, number of channels, 1..16
PERIOD_CYCLES, 20000000, clocks between periodic frames (1 s at 20 MHz); 0 disables the periodic timer
SEP_CHAR, 8'h20, byte emitted between channels

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
enable  in  1  enables the periodic timer and the start of new frames
trigger  in  1  single-cycle request for an immediate frame
data_in  in  NUM_CH*WORD_BITS  channel k = data_in[k*WORD_BITS +: WORD_BITS]
tx_data  out  8  ASCII byte to the UART transmitter
tx_valid  out  1  tx_data is valid
tx_ready  in  1  UART transmitter accepts a byte
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after the LF byte is accepted
overrun_cnt  out  8  saturating count of requests dropped while busy

Behaviour:
- Reset (async, rst=1): every register cleared. tx_valid=0, tx_data=0, busy=0, frame_done=0, overrun_cnt=0, pending=0, timer=0, state=IDLE.
- Timer: counts 0..PERIOD_CYCLES-1 while enable=1 and wraps. tick=1 in the cycle the count equals PERIOD_CYCLES-1. With enable=0 the timer holds at 0 and pending clears.
- Request: req = enable & (tick | trigger | pending). tick and trigger in the same cycle count as one request.
- Handshake: a byte transfers on a posedge with tx_valid & tx_ready.
  - tx_data and tx_valid are registered.
  - tx_data stays stable while tx_valid=1 and tx_ready=0.
  - tx_valid never drops without a transfer, except on reset.
- FSM states: IDLE, HEX, SEP, CR, LF.
  - IDLE, req=1: snapshot data_in into an internal register; ch=0, nib=NIB-1; tx_data=hex(snapshot ch0 top nibble); tx_valid=1; busy=1; pending=0; go to HEX. First byte is valid the cycle after the request (latency 1).
  - HEX, on transfer: if nib>0, nib-- and load the next nibble. Else if ch<NUM_CH-1, load SEP_CHAR and go to SEP. Else load 8'h0D and go to CR.
  - SEP, on transfer: ch++, nib=NIB-1, load the hex nibble, go to HEX.
  - CR, on transfer: load 8'h0A, go to LF.
  - LF, on transfer: tx_valid=0, busy=0, frame_done=1 for one cycle, go to IDLE. A waiting request starts the next frame on the following cycle (one idle cycle minimum).
- Byte order: channel 0 first; within a word, most-significant nibble first. Hex digits are uppercase: 0-9 -> 8'h30-8'h39, A-F -> 8'h41-8'h46.
- Frame length: NUM_CH*NIB + (NUM_CH-1) + 2 bytes.
- Snapshot: data_in changes after frame start do not affect the frame.
- Request while busy (enable=1):
  - pending=0: set pending=1.
  - pending=1: pending stays 1 and overrun_cnt increments, saturating at 255.
- enable dropped mid-frame: the current frame completes; pending clears; no new frame starts.
- Reset mid-frame: tx_valid drops immediately. The frame is abandoned with no CR/LF completion.

Decomposition:
- Package uart_dbg_pkg holds:
  - state enum (IDLE, HEX, SEP, CR, LF)
  - ASCII_CR=8'h0D, ASCII_LF=8'h0A
  - hex_ascii function (4-bit to uppercase ASCII)
- One sub-module, dbg_tick_gen: the PERIOD_CYCLES timer with enable and single-cycle tick output; PERIOD_CYCLES=0 ties tick to 0.

Test Plan:
- NUM_CH=2, WORD_BITS=16, data_in={16'hBEEF,16'h12A0}, tx_ready=1, one trigger pulse -> expected response:
  - bytes 31 32 41 30 20 42 45 45 46 0D 0A, one per cycle after a 1-cycle latency
  - frame_done pulses once
  - busy high for exactly 11 cycles
- Same setup with tx_ready random 30% duty -> same 11-byte sequence; tx_data never changes while tx_valid=1 and tx_ready=0; no byte duplicated or lost.
- Snapshot: change data_in to 32'h0 after the 2nd byte -> line is still "12A0 BEEF\r\n"; the next trigger yields "0000 0000\r\n".
- PERIOD_CYCLES=200, enable=1, no trigger, tx_ready=1 -> tx_valid rises at cycles 200 and 400 after reset release. Drop enable at cycle 250 -> no frame at 400.
- Overrun: three trigger pulses during a frame -> exactly one extra frame follows the current one; overrun_cnt=2.
- Reset mid-frame: assert rst after the 5th byte transfers -> tx_valid=0 asynchronously, overrun_cnt=0. After release there is no output until the next trigger or tick; the next frame is complete and correct.
